// File: rtl/fp_adder_pkg.sv
// Shared fp-adder widths and the aligned-result bundle handed from the alignment
// stage to the rounding stage.
package fp_adder_pkg;

  localparam int SIZE_MOST_S_MANTISSA  = 24;
  localparam int SIZE_LEAST_S_MANTISSA = 25;
  localparam int SIZE_EXP_DIFF         = 8;

  localparam int ALIGN_WINDOW = SIZE_MOST_S_MANTISSA + SIZE_LEAST_S_MANTISSA;
  localparam int ALIGN_SAT    = ALIGN_WINDOW;

  typedef struct packed {
    logic [SIZE_MOST_S_MANTISSA-1:0]  unrounded_mantissa;
    logic [SIZE_LEAST_S_MANTISSA-1:0] dummy_bits;
    logic                             correction;
  } align_result_t;

endpackage

// File: rtl/far_path_align_if.sv
// Handshake and data bundle of the far-path alignment stage; the slave modport
// is the stage itself, the master modport is its surroundings.
interface far_path_align_if #(
  parameter int SIZE_MOST_S_MANTISSA  = fp_adder_pkg::SIZE_MOST_S_MANTISSA,
  parameter int SIZE_LEAST_S_MANTISSA = fp_adder_pkg::SIZE_LEAST_S_MANTISSA,
  parameter int SIZE_EXP_DIFF         = fp_adder_pkg::SIZE_EXP_DIFF
);

  logic                             in_valid;
  logic                             in_ready;
  logic [SIZE_MOST_S_MANTISSA-1:0]  in_mantissa;
  logic [SIZE_EXP_DIFF-1:0]         in_exp_diff;
  logic                             in_sub;
  logic                             out_valid;
  logic                             out_ready;
  logic [SIZE_MOST_S_MANTISSA-1:0]  unrounded_mantissa;
  logic [SIZE_LEAST_S_MANTISSA-1:0] dummy_bits;
  logic                             correction;

  modport master (
    output in_valid, in_mantissa, in_exp_diff, in_sub, out_ready,
    input  in_ready, out_valid, unrounded_mantissa, dummy_bits, correction
  );

  modport slave (
    input  in_valid, in_mantissa, in_exp_diff, in_sub, out_ready,
    output in_ready, out_valid, unrounded_mantissa, dummy_bits, correction
  );

endinterface

// File: rtl/align_shift_sticky.sv
// Combinational logical right shift that reports whether any set bit fell off the
// bottom, OR-ed with an incoming sticky from an earlier partial shift.
module align_shift_sticky #(
  parameter int WIDTH   = 49,
  parameter int SHIFT_W = 8
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHIFT_W-1:0] shamt,
  input  logic               sticky_in,
  output logic [WIDTH-1:0]   dout,
  output logic               sticky_out
);

  logic [WIDTH-1:0] keep_mask;

  // Shifts of WIDTH or more zero the mask, so every input bit counts as lost.
  always_comb begin
    dout       = din >> shamt;
    keep_mask  = {WIDTH{1'b1}} << shamt;
    sticky_out = sticky_in | (|(din & ~keep_mask));
  end

endmodule

// File: rtl/far_path_align.sv
// Two-stage far-path alignment (coarse byte shift, then fine bit shift) with stall
// handshake. Optional `FAR_PATH_ALIGN_SAT_CNT_EN adds a saturated-shift counter.
module far_path_align
  import fp_adder_pkg::*;
#(
  parameter int SIZE_MOST_S_MANTISSA  = fp_adder_pkg::SIZE_MOST_S_MANTISSA,
  parameter int SIZE_LEAST_S_MANTISSA = fp_adder_pkg::SIZE_LEAST_S_MANTISSA,
  parameter int SIZE_EXP_DIFF         = fp_adder_pkg::SIZE_EXP_DIFF
) (
  input  logic             clk,
  input  logic             rst,
  far_path_align_if.slave  bus
`ifdef FAR_PATH_ALIGN_SAT_CNT_EN
  ,
  output logic [15:0]      sat_count
`endif
);

  localparam int WIN = SIZE_MOST_S_MANTISSA + SIZE_LEAST_S_MANTISSA;

  logic                             s1_valid, s2_valid, s1_adv, s2_load;
  logic [WIN-1:0]                   win_in, coarse_out, fine_out, s1_window;
  logic [SIZE_EXP_DIFF-1:0]         coarse_amt;
  logic                             coarse_sticky, fine_sticky, s1_sticky, s1_sub;
  logic [2:0]                       s1_fine;
  logic [SIZE_LEAST_S_MANTISSA-1:0] dummy_d, dummy_q;
  logic [SIZE_MOST_S_MANTISSA-1:0]  um_q;
  logic                             corr_d, corr_q;

  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_adv       = s2_load || !s1_valid;
  assign bus.in_ready = s1_adv;

  assign win_in     = {bus.in_mantissa, {SIZE_LEAST_S_MANTISSA{1'b0}}};
  assign coarse_amt = {bus.in_exp_diff[SIZE_EXP_DIFF-1:3], 3'b000};

  align_shift_sticky #(.WIDTH(WIN), .SHIFT_W(SIZE_EXP_DIFF)) u_coarse (
    .din(win_in), .shamt(coarse_amt), .sticky_in(1'b0),
    .dout(coarse_out), .sticky_out(coarse_sticky)
  );

  align_shift_sticky #(.WIDTH(WIN), .SHIFT_W(3)) u_fine (
    .din(s1_window), .shamt(s1_fine), .sticky_in(s1_sticky),
    .dout(fine_out), .sticky_out(fine_sticky)
  );

  // Everything lost in either stage collapses into the lowest dummy bit.
  assign dummy_d = {fine_out[SIZE_LEAST_S_MANTISSA-1:1], fine_out[0] | fine_sticky};
  assign corr_d  = s1_sub & (|dummy_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_window <= '0;
      s1_sticky <= 1'b0;
      s1_fine   <= '0;
      s1_sub    <= 1'b0;
      s2_valid  <= 1'b0;
      um_q      <= '0;
      dummy_q   <= '0;
      corr_q    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid  <= bus.in_valid;
        s1_window <= coarse_out;
        s1_sticky <= coarse_sticky;
        s1_fine   <= bus.in_exp_diff[2:0];
        s1_sub    <= bus.in_sub;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        um_q     <= fine_out[WIN-1:SIZE_LEAST_S_MANTISSA];
        dummy_q  <= dummy_d;
        corr_q   <= corr_d;
      end
    end
  end

  assign bus.out_valid          = s2_valid;
  assign bus.unrounded_mantissa = um_q;
  assign bus.dummy_bits         = dummy_q;
  assign bus.correction         = corr_q;

`ifdef FAR_PATH_ALIGN_SAT_CNT_EN
  localparam logic [SIZE_EXP_DIFF-1:0] SAT_D = SIZE_EXP_DIFF'(ALIGN_SAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (bus.in_valid && s1_adv && (bus.in_exp_diff >= SAT_D)
                 && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_far_path_align.sv
// Scoreboard bench for far_path_align: directed vectors push expected results,
// a negedge monitor pops and compares whenever an output transfer is presented.
module tb_far_path_align;
  import fp_adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
`ifdef FAR_PATH_ALIGN_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  far_path_align_if bus ();

  far_path_align dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FAR_PATH_ALIGN_SAT_CNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  align_result_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int n_pushed     = 0;
  int n_popped     = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference: one position per step, remembering anything that drops off.
  function automatic align_result_t model(input logic [23:0] m, input logic [7:0] d,
                                          input logic sub);
    align_result_t r;
    logic [48:0] w;
    logic st;
    w  = {m, 25'b0};
    st = 1'b0;
    for (int i = 0; i < int'(d); i++) begin
      st = st | w[0];
      w  = w >> 1;
    end
    r.unrounded_mantissa = w[48:25];
    r.dummy_bits         = {w[24:1], w[0] | st};
    r.correction         = sub & (r.dummy_bits != 25'h0);
    return r;
  endfunction

  // Called just after a rising edge; returns 1ns after the edge that accepted the beat.
  task automatic applyStimulus(input logic [23:0] m, input logic [7:0] d, input logic sub,
                               input align_result_t exp_r);
    int waited;
    bus.in_valid    = 1'b1;
    bus.in_mantissa = m;
    bus.in_exp_diff = d;
    bus.in_sub      = sub;
    waited = 0;
    forever begin
      @(posedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 100) begin
        checkOutput("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        break;
      end
    end
    exp_q.push_back(exp_r);
    n_pushed++;
    #1;
  endtask

  task automatic idleInput();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int cycles;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: scoreboard pop, stall stability and in_ready legality.
  initial begin
    align_result_t held, act, e;
    logic held_valid;
    held_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      act = '{bus.unrounded_mantissa, bus.dummy_bits, bus.correction};
      if (rst) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid) begin
          tests_run++;
          if (!bus.out_valid || act !== held) begin
            tests_failed++;
            $display("[TB] FAIL stall_stable: got valid=%0b %h expected valid=1 %h",
                     bus.out_valid, act, held);
          end
        end
        if (!bus.in_ready) begin
          tests_run++;
          if (!(bus.out_valid && !bus.out_ready)) begin
            tests_failed++;
            $display("[TB] FAIL in_ready_low: got in_ready=0 with out_valid=%0b out_ready=%0b",
                     bus.out_valid, bus.out_ready);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_output: got %h expected none", act);
          end else begin
            e = exp_q.pop_front();
            n_popped++;
            if (act !== e) begin
              tests_failed++;
              $display("[TB] FAIL result: got um=%h dummy=%h corr=%0b expected um=%h dummy=%h corr=%0b",
                       act.unrounded_mantissa, act.dummy_bits, act.correction,
                       e.unrounded_mantissa, e.dummy_bits, e.correction);
            end
          end
        end
        held_valid = bus.out_valid && !bus.out_ready;
        held = act;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [23:0]   s_m[8] = '{24'hFFFFFF, 24'h800000, 24'hABCDEF, 24'h123456,
                            24'hC00001, 24'h000001, 24'h7FFFFF, 24'h955555};
  logic [7:0]    s_d[8] = '{8'd0, 8'd3, 8'd11, 8'd17, 8'd26, 8'd47, 8'd48, 8'd49};
  logic [3:0]    ready_pat = 4'b1001;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mantissa = '0;
    bus.in_exp_diff = '0;
    bus.in_sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_outputs", {bus.unrounded_mantissa, bus.dummy_bits, bus.correction}, 64'd0);
`ifdef FAR_PATH_ALIGN_SAT_CNT_EN
    checkOutput("rst_sat_count", 64'(sat_count), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(24'hC00001, 8'd0, 1'b0, '{24'hC00001, 25'h0, 1'b0});
    idleInput();
    checkOutput("latency_cycle1", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_cycle2", 64'(bus.out_valid), 64'd1);
    waitDrain();

    applyStimulus(24'hC00001, 8'd1,  1'b1, '{24'h600000, 25'h1000000, 1'b1});
    applyStimulus(24'hC00001, 8'd24, 1'b0, '{24'h000000, 25'h1800002, 1'b0});
    applyStimulus(24'hC00001, 8'd30, 1'b0, '{24'h000000, 25'h0060001, 1'b0});
    applyStimulus(24'hC00001, 8'd8,  1'b0, '{24'h00C000, 25'h0020000, 1'b0});
    applyStimulus(24'hC00001, 8'd13, 1'b1, '{24'h000600, 25'h0001000, 1'b1});
    applyStimulus(24'hC00001, 8'd25, 1'b0, '{24'h000000, 25'h0C00001, 1'b0});
    applyStimulus(24'hC00001, 8'd48, 1'b0, '{24'h000000, 25'h0000001, 1'b0});
    idleInput();
    waitDrain();
`ifdef FAR_PATH_ALIGN_SAT_CNT_EN
    checkOutput("sat_count_before", 64'(sat_count), 64'd0);
`endif
    applyStimulus(24'h800000, 8'd200, 1'b1, '{24'h000000, 25'h0000001, 1'b1});
    idleInput();
    waitDrain();
`ifdef FAR_PATH_ALIGN_SAT_CNT_EN
    checkOutput("sat_count_after", 64'(sat_count), 64'd1);
`endif
    applyStimulus(24'h000000, 8'd200, 1'b1, '{24'h000000, 25'h0000000, 1'b0});
    idleInput();
    waitDrain();

    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(s_m[i], s_d[i], 1'(i), model(s_m[i], s_d[i], 1'(i)));
        idleInput();
      end
      begin
        for (int c = 0; c < 40; c++) begin
          bus.out_ready = ready_pat[3 - (c % 4)];
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    waitDrain();

    bus.out_ready = 1'b0;
    applyStimulus(24'h123456, 8'd4, 1'b0, model(24'h123456, 8'd4, 1'b0));
    applyStimulus(24'hABCDEF, 8'd9, 1'b1, model(24'hABCDEF, 8'd9, 1'b1));
    idleInput();
    rst = 1'b1;
    n_pushed = n_pushed - exp_q.size();
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("midrst_outputs", {bus.unrounded_mantissa, bus.dummy_bits, bus.correction}, 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(24'hC00001, 8'd1, 1'b1, '{24'h600000, 25'h1000000, 1'b1});
    idleInput();
    checkOutput("postrst_lat1", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("postrst_lat2", 64'(bus.out_valid), 64'd1);
    waitDrain();

    repeat (2) @(posedge clk);
    checkOutput("pushed_vs_popped", 64'(n_popped), 64'(n_pushed));
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/far_path_align.md
Name: far_path_align

Overview:
- Pipelined alignment stage directly upstream of the rounding stage in the dual-path FP adder.
- Takes the smaller operand's significand (hidden bit included) and the exponent difference.
- Right-shifts the significand into a {most-significant, least-significant} window and folds lost bits into a sticky LSB.
- Produces the unrounded_mantissa / dummy_bits / correction triple the rounding stage consumes, with a valid/ready handshake.

Parameters:
- SIZE_MOST_S_MANTISSA, 24, width of significand and of aligned high part.
- SIZE_LEAST_S_MANTISSA, 25, width of dummy (guard/round/sticky) field.
- SIZE_EXP_DIFF, 8, width of unsigned exponent-difference input.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  stage can accept input
- in_mantissa  in  SIZE_MOST_S_MANTISSA  significand to align
- in_exp_diff  in  SIZE_EXP_DIFF  right-shift amount (unsigned)
- in_sub  in  1  effective subtraction
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts
- unrounded_mantissa  out  SIZE_MOST_S_MANTISSA  aligned high part
- dummy_bits  out  SIZE_LEAST_S_MANTISSA  shifted-out bits, bit0 holds sticky OR
- correction  out  1  in_sub AND (dummy_bits != 0)

Behaviour:
- Window W = {in_mantissa, SIZE_LEAST_S_MANTISSA zeros}, 49 bits by default.
- Result = W >> d, where d = in_exp_diff.
  - unrounded_mantissa = Result[48:25].
  - dummy_bits[24:1] = Result[24:1].
  - dummy_bits[0] = Result[0] OR (OR of all bits shifted below bit 0).
- Saturation: if d >= 49, unrounded_mantissa = 0 and dummy_bits = {24'b0, |in_mantissa}.
- d = 0: output equals input; dummy_bits = 0.
- Two register stages, latency exactly 2 cycles from accepted input to out_valid when there is no stall.
  - S1 (coarse): shift by d[SIZE_EXP_DIFF-1:3]*8 with saturation. Registers the partial window, partial sticky, d[2:0], in_sub and s1_valid.
  - S2 (fine): shift by d[2:0], completes sticky, computes correction. Registers outputs and s2_valid.
- Handshake:
  - Transfer occurs on valid AND ready at the rising edge.
  - out_valid = s2_valid.
  - S2 loads when !s2_valid OR out_ready.
  - S1 advances when S2 loads or !s1_valid.
  - in_ready = !s1_valid OR S2 loads. This is a full-throughput stall pipeline: one transfer per cycle at steady state, no bubbles inserted, no transaction dropped or duplicated.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Reset (any cycle, including mid-transaction):
  - s1_valid = s2_valid = 0; out_valid = 0; in_ready = 1 in the following cycle.
  - unrounded_mantissa = 0, dummy_bits = 0, correction = 0.
  - In-flight data is discarded.
- Simultaneous input accept and output drain in one cycle is legal and required.
- Output data registers update only on S2 load; they are not gated by valid otherwise.

Optional Feature:
- Macro FAR_PATH_ALIGN_SAT_CNT_EN.
- When defined:
  - Extra output sat_count (16 bits).
  - Increments on each accepted input with in_exp_diff >= 49, saturating at 16'hFFFF.
  - Cleared by rst.
- When undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package fp_adder_pkg holds:
  - SIZE_MOST_S_MANTISSA, SIZE_LEAST_S_MANTISSA, SIZE_EXP_DIFF defaults.
  - Derived ALIGN_WINDOW = 49 and ALIGN_SAT = 49.
  - Packed struct type for the {unrounded_mantissa, dummy_bits, correction} bundle, shared with the rounding stage.
- One sub-module: align_shift_sticky. Combinational right shift with sticky fold, parameterised by shift-amount width; instantiated once per stage.

Test Plan:
- m=24'hC00001, d=0, sub=0 -> after 2 cycles: unrounded=24'hC00001, dummy=25'h0, correction=0.
- m=24'hC00001, d=1, sub=1 -> unrounded=24'h600000, dummy=25'h1000000, correction=1.
- m=24'hC00001, d=24 -> unrounded=0, dummy=25'h1800002. Then d=30 -> unrounded=0, dummy=25'h0060001 (sticky from lost LSB).
- m=24'h800000, d=200, sub=1 -> unrounded=0, dummy=25'h0000001, correction=1. With FAR_PATH_ALIGN_SAT_CNT_EN, sat_count goes 0->1.
- Back-to-back stream of 8 transactions while out_ready is toggled 1,0,0,1,… -> all 8 outputs in order, none lost or duplicated; outputs stable during stall; in_ready=0 only while both stages are full and out_ready=0.
- rst asserted while 2 transactions are in flight -> next cycle out_valid=0, in_ready=1, outputs zero; the next accepted input appears 2 cycles later with correct values.
